lsu_mem_access: RTL and testbench
=================================

// Module: lsu_mem_access
// PURPOSE
//  LSU memory stage, directly downstream of the LSU execute stage. Takes one resolved load/store
//  per accept; drives a valid/ready memory request port; waits for load data; emits a one-cycle
//  register-file writeback. Replaces the "1-cycle memory" model with a handshaked multi-cycle one.
// PARAMETERS
//  ADDR_W          32  byte-address width
//  DATA_W          32  data width (word accesses only)
//  REG_IDX_W       5   register index width
//  TIMEOUT_CYCLES  64  max WAIT cycles before abort; 0 = timeout disabled
// PORTS
//  clk            in   1          clock, all state on rising edge
//  rst            in   1          synchronous, active-high reset
//  ex_valid       in   1          execute stage presents an op
//  ex_ready       out  1          stage can accept (1 only in IDLE)
//  ex_is_load     in   1          1 = load, 0 = store/nop
//  ex_wr_en       in   1          1 = store (with !ex_is_load); both 0 = nop
//  ex_rd_addr     in   ADDR_W     load effective address
//  ex_wr_addr     in   ADDR_W     store effective address
//  ex_wr_data     in   DATA_W     store data
//  ex_rd_idx      in   REG_IDX_W  load destination register
//  mem_req_valid  out  1          request valid
//  mem_req_ready  in   1          memory accepts request
//  mem_req_we     out  1          1 = write
//  mem_req_addr   out  ADDR_W     request address
//  mem_req_wdata  out  DATA_W     write data
//  mem_rsp_valid  in   1          load data valid
//  mem_rsp_rdata  in   DATA_W     load data
//  wb_valid       out  1          one-cycle writeback strobe
//  wb_rd_idx      out  REG_IDX_W  writeback register
//  wb_data        out  DATA_W     writeback data
//  timeout        out  1          one-cycle pulse: load aborted in WAIT
//  misalign       out  1          one-cycle pulse: access rejected (0 unless macro defined)
// BEHAVIOUR
//  - States: IDLE, REQ, WAIT. Reset -> IDLE; all outputs 0 except ex_ready=1; counter 0.
//  - IDLE: accept on ex_valid&&ex_ready; latch addr (load: ex_rd_addr, store: ex_wr_addr), data,
//    rd_idx, we. Load or store -> REQ next cycle. Nop (!is_load&&!wr_en) consumed, stays IDLE.
//  - REQ: mem_req_valid=1; addr/we/wdata held stable until mem_req_ready. On handshake: store ->
//    IDLE (done on acceptance, no response expected); load -> WAIT, counter cleared.
//  - WAIT: mem_rsp_valid sampled only here (memory latency >=1 cycle after handshake; rsp outside
//    WAIT ignored). On rsp: wb_valid=1 for exactly one cycle, wb_data=mem_rsp_rdata registered,
//    -> IDLE. wb_valid suppressed if rd_idx==0 (access still performed).
//  - Timeout: counter increments each WAIT cycle w/o rsp; reaching TIMEOUT_CYCLES -> timeout pulse,
//    no wb, -> IDLE. Rsp in the same cycle as expiry wins (wb, no timeout).
//  - Latency: accept->req = 1 cycle; rsp->wb_valid = 1 cycle. Min throughput: store 2, load 3+.
//  - wb_rd_idx/wb_data hold last value when wb_valid=0; mem_req_* are 0 outside REQ.
//  - rst mid-operation: in-flight op dropped, no wb, outputs to reset values next cycle; a late
//    rsp after reset is ignored (not in WAIT).
// CONFIGURATION
//  LSU_MISALIGN_CHECK_EN defined: accepted load/store with addr[1:0]!=0 issues no request;
//    misalign pulses one cycle after accept; stays IDLE.
//  Undefined: misalign tied 0; address passed to mem_req_addr unmodified.
// STRUCTURE
//  - lsu_pkg: lsu_state_t enum {IDLE,REQ,WAIT}; LSU_ADDR_W/LSU_DATA_W/LSU_REG_IDX_W constants.
//  - Sub-module lsu_wait_timer: clear/enable/expire counter, width $clog2(TIMEOUT_CYCLES+1).
// TESTING
//  1 Store addr 0x100 data 0xDEADBEEF, ready=1 -> one req (we=1) next cycle, ex_ready=1 after.
//  2 Load 0x40 rd=5, ready after 3 cycles, rsp 2 cycles later 0x1234 -> wb_valid 1 cycle, rd=5.
//  3 Load rd=0 -> request issued, rsp returned, wb_valid never asserted.
//  4 Load, no rsp, TIMEOUT_CYCLES=4 -> timeout pulse after 4 WAIT cycles; late rsp ignored.
//  5 rst asserted in WAIT -> IDLE next cycle, outputs reset, following rsp produces no wb.
//  6 Macro on: load 0x102 -> no mem_req_valid, misalign pulse; macro off: req addr 0x102.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and default widths for the LSU memory stage.
package lsu_pkg;

    localparam int LSU_ADDR_W    = 32;
    localparam int LSU_DATA_W    = 32;
    localparam int LSU_REG_IDX_W = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } lsu_state_t;

endpackage

// File: rtl/lsu_wait_timer.sv
// Response-wait counter: cleared on entry to the wait phase, counts idle wait cycles,
// flags expiry on the TIMEOUT_CYCLES-th one. TIMEOUT_CYCLES == 0 never expires.
module lsu_wait_timer #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    generate
        if (TIMEOUT_CYCLES > 0) begin : g_timeout
            localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);
            // Expiry fires during the last allowed idle cycle so the abort lands on its edge.
            assign expire = enable && (count_q == LAST);
        end else begin : g_no_timeout
            assign expire = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/lsu_mem_access.sv
// LSU memory stage: accepts one load/store, runs a valid/ready request, waits for load data,
// emits a one-cycle writeback. Optional feature macro: LSU_MISALIGN_CHECK_EN.
module lsu_mem_access
    import lsu_pkg::*;
#(
    parameter int ADDR_W         = LSU_ADDR_W,
    parameter int DATA_W         = LSU_DATA_W,
    parameter int REG_IDX_W      = LSU_REG_IDX_W,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ex_valid,
    output logic                 ex_ready,
    input  logic                 ex_is_load,
    input  logic                 ex_wr_en,
    input  logic [ADDR_W-1:0]    ex_rd_addr,
    input  logic [ADDR_W-1:0]    ex_wr_addr,
    input  logic [DATA_W-1:0]    ex_wr_data,
    input  logic [REG_IDX_W-1:0] ex_rd_idx,
    output logic                 mem_req_valid,
    input  logic                 mem_req_ready,
    output logic                 mem_req_we,
    output logic [ADDR_W-1:0]    mem_req_addr,
    output logic [DATA_W-1:0]    mem_req_wdata,
    input  logic                 mem_rsp_valid,
    input  logic [DATA_W-1:0]    mem_rsp_rdata,
    output logic                 wb_valid,
    output logic [REG_IDX_W-1:0] wb_rd_idx,
    output logic [DATA_W-1:0]    wb_data,
    output logic                 timeout,
    output logic                 misalign
);

    lsu_state_t           state_q, state_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [DATA_W-1:0]    wdata_q, wdata_d;
    logic [REG_IDX_W-1:0] rd_idx_q, rd_idx_d;
    logic                 we_q, we_d;
    logic                 wb_valid_q, wb_valid_d;
    logic [REG_IDX_W-1:0] wb_rd_idx_q, wb_rd_idx_d;
    logic [DATA_W-1:0]    wb_data_q, wb_data_d;
    logic                 timeout_q, timeout_d;
    logic                 misalign_q, misalign_d;

    logic [ADDR_W-1:0]    sel_addr;
    logic                 timer_clear;
    logic                 timer_en;
    logic                 timer_expire;
    logic                 req_active;

    lsu_wait_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_wait_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (timer_clear),
        .enable (timer_en),
        .expire (timer_expire)
    );

    assign sel_addr = ex_is_load ? ex_rd_addr : ex_wr_addr;
    assign timer_en = (state_q == WAIT) && !mem_rsp_valid;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rd_idx_d    = rd_idx_q;
        we_d        = we_q;
        wb_valid_d  = 1'b0;
        wb_rd_idx_d = wb_rd_idx_q;
        wb_data_d   = wb_data_q;
        timeout_d   = 1'b0;
        misalign_d  = 1'b0;
        timer_clear = 1'b0;

        case (state_q)
            IDLE: begin
                if (ex_valid) begin
                    addr_d   = sel_addr;
                    wdata_d  = ex_wr_data;
                    rd_idx_d = ex_rd_idx;
                    we_d     = !ex_is_load && ex_wr_en;
                    // Nops are consumed here without touching memory.
                    if (ex_is_load || ex_wr_en) begin
`ifdef LSU_MISALIGN_CHECK_EN
                        if (sel_addr[1:0] != 2'b00) begin
                            misalign_d = 1'b1;
                        end else begin
                            state_d = REQ;
                        end
`else
                        state_d = REQ;
`endif
                    end
                end
            end
            REQ: begin
                if (mem_req_ready) begin
                    if (we_q) begin
                        state_d = IDLE;
                    end else begin
                        state_d     = WAIT;
                        timer_clear = 1'b1;
                    end
                end
            end
            WAIT: begin
                // A response arriving on the expiry cycle still wins over the abort.
                if (mem_rsp_valid) begin
                    state_d = IDLE;
                    if (rd_idx_q != '0) begin
                        wb_valid_d  = 1'b1;
                        wb_rd_idx_d = rd_idx_q;
                        wb_data_d   = mem_rsp_rdata;
                    end
                end else if (timer_expire) begin
                    state_d   = IDLE;
                    timeout_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            wb_valid_q  <= 1'b0;
            wb_rd_idx_q <= '0;
            wb_data_q   <= '0;
            timeout_q   <= 1'b0;
            misalign_q  <= 1'b0;
            we_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            wb_valid_q  <= wb_valid_d;
            wb_rd_idx_q <= wb_rd_idx_d;
            wb_data_q   <= wb_data_d;
            timeout_q   <= timeout_d;
            misalign_q  <= misalign_d;
            we_q        <= we_d;
        end
    end

    // Request payload is only meaningful while a request is outstanding.
    always_ff @(posedge clk) begin
        addr_q   <= addr_d;
        wdata_q  <= wdata_d;
        rd_idx_q <= rd_idx_d;
    end

    assign req_active    = (state_q == REQ);
    assign ex_ready      = (state_q == IDLE);
    assign mem_req_valid = req_active;
    assign mem_req_we    = req_active && we_q;
    assign mem_req_addr  = req_active ? addr_q : '0;
    assign mem_req_wdata = req_active ? wdata_q : '0;
    assign wb_valid      = wb_valid_q;
    assign wb_rd_idx     = wb_rd_idx_q;
    assign wb_data       = wb_data_q;
    assign timeout       = timeout_q;
    assign misalign      = misalign_q;

endmodule

// File: tb/tb_lsu_mem_access.sv
// Directed bench for lsu_mem_access with TIMEOUT_CYCLES = 4; follows LSU_MISALIGN_CHECK_EN.
module tb_lsu_mem_access;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic        ex_ready;
    logic        ex_is_load;
    logic        ex_wr_en;
    logic [31:0] ex_rd_addr;
    logic [31:0] ex_wr_addr;
    logic [31:0] ex_wr_data;
    logic [4:0]  ex_rd_idx;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_req_we;
    logic [31:0] mem_req_addr;
    logic [31:0] mem_req_wdata;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_rdata;
    logic        wb_valid;
    logic [4:0]  wb_rd_idx;
    logic [31:0] wb_data;
    logic        timeout;
    logic        misalign;

    int n_tests = 0;
    int n_fail  = 0;

    lsu_mem_access #(
        .ADDR_W         (32),
        .DATA_W         (32),
        .REG_IDX_W      (5),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .ex_valid      (ex_valid),
        .ex_ready      (ex_ready),
        .ex_is_load    (ex_is_load),
        .ex_wr_en      (ex_wr_en),
        .ex_rd_addr    (ex_rd_addr),
        .ex_wr_addr    (ex_wr_addr),
        .ex_wr_data    (ex_wr_data),
        .ex_rd_idx     (ex_rd_idx),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_we    (mem_req_we),
        .mem_req_addr  (mem_req_addr),
        .mem_req_wdata (mem_req_wdata),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_rdata (mem_rsp_rdata),
        .wb_valid      (wb_valid),
        .wb_rd_idx     (wb_rd_idx),
        .wb_data       (wb_data),
        .timeout       (timeout),
        .misalign      (misalign)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic issue_load(input logic [31:0] addr, input logic [4:0] rd);
        ex_valid   = 1'b1;
        ex_is_load = 1'b1;
        ex_wr_en   = 1'b0;
        ex_rd_addr = addr;
        ex_rd_idx  = rd;
        step();
        ex_valid   = 1'b0;
        ex_is_load = 1'b0;
    endtask

    initial begin
        rst           = 1'b1;
        ex_valid      = 1'b0;
        ex_is_load    = 1'b0;
        ex_wr_en      = 1'b0;
        ex_rd_addr    = '0;
        ex_wr_addr    = '0;
        ex_wr_data    = '0;
        ex_rd_idx     = '0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_rdata = '0;
        step();
        step();

        chk("rst_ex_ready", ex_ready, 1);
        chk("rst_req_valid", mem_req_valid, 0);
        chk("rst_req_addr", mem_req_addr, 0);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_wb_data", wb_data, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_misalign", misalign, 0);
        rst = 1'b0;
        step();

        // Store, memory always ready.
        ex_valid      = 1'b1;
        ex_wr_en      = 1'b1;
        ex_wr_addr    = 32'h100;
        ex_wr_data    = 32'hDEADBEEF;
        mem_req_ready = 1'b1;
        step();
        ex_valid = 1'b0;
        ex_wr_en = 1'b0;
        chk("st_req_valid", mem_req_valid, 1);
        chk("st_req_we", mem_req_we, 1);
        chk("st_req_addr", mem_req_addr, 32'h100);
        chk("st_req_wdata", mem_req_wdata, 32'hDEADBEEF);
        chk("st_ex_ready_busy", ex_ready, 0);
        step();
        chk("st_done_req_valid", mem_req_valid, 0);
        chk("st_done_ex_ready", ex_ready, 1);
        chk("st_done_wb_valid", wb_valid, 0);

        // Nop is consumed in IDLE.
        ex_valid = 1'b1;
        step();
        ex_valid = 1'b0;
        chk("nop_req_valid", mem_req_valid, 0);
        chk("nop_ex_ready", ex_ready, 1);

        // Load with ready after 3 request cycles, response 2 cycles into WAIT.
        mem_req_ready = 1'b0;
        issue_load(32'h40, 5'd5);
        chk("ld_req_valid_c1", mem_req_valid, 1);
        chk("ld_req_we", mem_req_we, 0);
        chk("ld_req_addr_c1", mem_req_addr, 32'h40);
        step();
        chk("ld_req_addr_c2", mem_req_addr, 32'h40);
        step();
        chk("ld_req_valid_c3", mem_req_valid, 1);
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        chk("ld_wait_req_valid", mem_req_valid, 0);
        chk("ld_wait_ex_ready", ex_ready, 0);
        step();
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = 32'h1234;
        chk("ld_wait_wb_valid", wb_valid, 0);
        step();
        mem_rsp_valid = 1'b0;
        chk("ld_wb_valid", wb_valid, 1);
        chk("ld_wb_rd_idx", wb_rd_idx, 5);
        chk("ld_wb_data", wb_data, 32'h1234);
        chk("ld_ex_ready", ex_ready, 1);
        step();
        chk("ld_wb_pulse_end", wb_valid, 0);
        chk("ld_wb_data_hold", wb_data, 32'h1234);

        // Load to x0: request performed, writeback suppressed.
        mem_req_ready = 1'b1;
        issue_load(32'h80, 5'd0);
        chk("x0_req_addr", mem_req_addr, 32'h80);
        step();
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = 32'h5555;
        step();
        mem_rsp_valid = 1'b0;
        chk("x0_wb_valid", wb_valid, 0);
        chk("x0_wb_data_hold", wb_data, 32'h1234);
        chk("x0_wb_idx_hold", wb_rd_idx, 5);
        chk("x0_ex_ready", ex_ready, 1);

        // Timeout after 4 idle WAIT cycles, late response ignored.
        mem_req_ready = 1'b1;
        issue_load(32'hC0, 5'd7);
        step();
        mem_req_ready = 1'b0;
        chk("to_wait1", timeout, 0);
        step();
        step();
        step();
        chk("to_wait4_timeout", timeout, 0);
        chk("to_wait4_ex_ready", ex_ready, 0);
        step();
        chk("to_pulse", timeout, 1);
        chk("to_wb_valid", wb_valid, 0);
        chk("to_ex_ready", ex_ready, 1);
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = 32'h9999;
        step();
        mem_rsp_valid = 1'b0;
        chk("to_pulse_end", timeout, 0);
        chk("to_late_rsp_wb", wb_valid, 0);
        chk("to_late_rsp_data", wb_data, 32'h1234);

        // Response on the expiry cycle wins.
        mem_req_ready = 1'b1;
        issue_load(32'hD0, 5'd9);
        step();
        mem_req_ready = 1'b0;
        step();
        step();
        step();
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = 32'hCAFE;
        step();
        mem_rsp_valid = 1'b0;
        chk("race_wb_valid", wb_valid, 1);
        chk("race_wb_data", wb_data, 32'hCAFE);
        chk("race_timeout", timeout, 0);
        step();

        // Reset while waiting for a response.
        mem_req_ready = 1'b1;
        issue_load(32'h10, 5'd3);
        step();
        mem_req_ready = 1'b0;
        chk("rw_in_wait", ex_ready, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rw_ex_ready", ex_ready, 1);
        chk("rw_wb_data", wb_data, 0);
        chk("rw_wb_idx", wb_rd_idx, 0);
        chk("rw_req_valid", mem_req_valid, 0);
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = 32'hAAAA;
        step();
        mem_rsp_valid = 1'b0;
        chk("rw_late_wb_valid", wb_valid, 0);
        chk("rw_late_wb_data", wb_data, 0);

        // Misaligned load.
        mem_req_ready = 1'b1;
        issue_load(32'h102, 5'd4);
`ifdef LSU_MISALIGN_CHECK_EN
        chk("mis_req_valid", mem_req_valid, 0);
        chk("mis_pulse", misalign, 1);
        chk("mis_ex_ready", ex_ready, 1);
        step();
        chk("mis_pulse_end", misalign, 0);
        chk("mis_no_req", mem_req_valid, 0);
`else
        chk("mis_req_valid", mem_req_valid, 1);
        chk("mis_req_addr", mem_req_addr, 32'h102);
        chk("mis_misalign", misalign, 0);
        step();
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = 32'h7777;
        step();
        mem_rsp_valid = 1'b0;
        chk("mis_wb_valid", wb_valid, 1);
        chk("mis_wb_idx", wb_rd_idx, 4);
        chk("mis_wb_data", wb_data, 32'h7777);
`endif
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
